sqrt_arbiter: RTL
=================

# sqrt_arbiter

Round-robin controller that shares one sequential square-root engine (`sqrt_pipe` instance, outside this block) among `N_REQ` requesters in the VGA render path. It accepts one operand at a time over a valid/ready handshake, sequences the engine's `start`/`finish` protocol, and returns each result tagged with the originating requester ID over a back-pressured result port. Only one operation is in flight at any time.

## Interface

- `N_REQ`, default 4: number of requesters, 2..16.
- `BIT_WIDTH`, default 12: operand and result width; even, ≥4; must match the engine.
- `ID_W`, default `$clog2(N_REQ)`: requester-ID width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_data`  in  N_REQ*BIT_WIDTH  packed operands; requester i uses bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_ready`  out  N_REQ  one-hot grant/accept.
- `res_valid`  out  1  result valid.
- `res_data`  out  BIT_WIDTH  floor(sqrt(operand)).
- `res_id`  out  ID_W  requester index.
- `res_err`  out  1  watchdog abort flag, qualified by `res_valid`.
- `res_ready`  in  1  result consumer ready.
- `sq_start`  out  1  engine start pulse.
- `sq_x`  out  BIT_WIDTH  engine operand.
- `sq_finish`  in  1  engine idle/finish level.
- `sq_result`  in  BIT_WIDTH  engine result.

## Operation

- FSM states: SYNC, IDLE, START, RUN, OUT.
- SYNC: reset state. Waits for `sq_finish`=1, then goes to IDLE, because the engine's finish is not valid out of reset.
- IDLE: picks the first asserted `req_valid` at or after index `last_grant+1` (mod N_REQ). `req_ready[g]` is driven combinationally in the same cycle, and the transfer completes that cycle. The block latches the operand into `sq_x`, latches `g` as the ID, updates `last_grant`, and goes to START. If no request is valid, it stays in IDLE. `req_valid` may drop without a transfer; arbitration is re-evaluated every IDLE cycle.
- START: `sq_start`=1 for exactly this cycle, then RUN.
- RUN: `sq_finish` is ignored in the first RUN cycle only if it is still high (engine latency guard). When `sq_finish`=1 is seen, the block captures `sq_result` into `res_data`, clears `res_err`, and goes to OUT.
- OUT: `res_valid`=1. `res_data`, `res_id`, and `res_err` are held stable until `res_ready`=1, then the FSM goes to IDLE.
- `req_ready` is all-zero in every state except IDLE.
- `sq_x` holds the latched operand in all states.

## Timing

- Reset values:
  - `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_err`=0, `sq_start`=0, `sq_x`=0.
  - state=SYNC.
  - `last_grant`=N_REQ-1, so requester 0 wins first.
- Latency, with acceptance in cycle T:
  - `sq_start` high in T+1.
  - Engine busy T+2..T+1+BIT_WIDTH/2.
  - `sq_finish` seen T+2+BIT_WIDTH/2.
  - `res_valid` in T+3+BIT_WIDTH/2 (T+9 at the default).
- Throughput: with `res_ready` held high, one operation per BIT_WIDTH/2+4 cycles.
- Back-pressure: OUT may last indefinitely. No new grant is issued while a result is pending.
- Reset mid-operation: all state is cleared immediately, with no result emitted. After `rst_n` deasserts, the block re-enters SYNC.

## Configuration

- `SQRT_ARB_WDT_EN` defined: RUN counts cycles. If `sq_finish` has not been seen after BIT_WIDTH/2+4 RUN cycles, the block aborts to OUT with `res_data`=0 and `res_err`=1.
- Not defined: no counter; `res_err` is tied to 0; RUN waits indefinitely.

## Structure

- Package `sqrt_arb_pkg` holds:
  - State encodings.
  - Watchdog limit function (BIT_WIDTH/2+4).
  - Default `N_REQ`/`BIT_WIDTH`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.
- The FSM, operand/result registers, and watchdog live in the top module.

## Test plan

- Single request: requester 2 presents 144 → `req_ready[2]` in the same cycle; `res_valid` 9 cycles later with `res_data`=12, `res_id`=2, `res_err`=0.
- Boundary operands from requester 0: 0→0, 1→1, 2→1, 15→3, 4095→63.
- All four requesters valid continuously with operands 16/25/36/49 → grants in order 0,1,2,3,0; results 4,5,6,7 tagged with matching IDs.
- `res_ready` held low for 20 cycles in OUT → `res_data`/`res_id` stable, `req_ready` all 0, no `sq_start`. Release → IDLE the next cycle.
- Reset tests:
  - `rst_n` pulsed low during RUN → outputs reset immediately, no `res_valid`.
  - After reset the block waits in SYNC while the engine model holds `sq_finish`=0 for 8 cycles.
- With `SQRT_ARB_WDT_EN`, the engine model never raises `sq_finish` → `res_valid` with `res_data`=0 and `res_err`=1 after 10 RUN cycles. The next request completes normally.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared constants for the square-root engine arbiter: FSM encodings,
// default geometry and the watchdog limit used when SQRT_ARB_WDT_EN is defined.
package sqrt_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_BIT_WIDTH = 12;

    localparam logic [2:0] ST_SYNC  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // RUN cycles allowed before the engine is declared hung.
    function automatic int wdt_limit(input int bit_width);
        return bit_width / 2 + 4;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first asserted request
// strictly after last_grant (wrapping), as a one-hot vector plus its index.
module rr_pick
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one sequential sqrt engine among N_REQ requesters.
// Define SQRT_ARB_WDT_EN to add a RUN watchdog that aborts hung operations with res_err.
//
//   state | meaning
//   SYNC  | after reset, wait for the engine to report finish
//   IDLE  | arbitrate; accept one operand in the cycle req_ready is high
//   START | one-cycle sq_start pulse
//   RUN   | wait for sq_finish (first cycle ignored), or watchdog expiry
//   OUT   | hold tagged result until res_ready
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       res_valid,
    output logic [BIT_WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       res_err,
    input  logic                       res_ready,
    output logic                       sq_start,
    output logic [BIT_WIDTH-1:0]       sq_x,
    input  logic                       sq_finish,
    input  logic [BIT_WIDTH-1:0]       sq_result
);

    logic [2:0]           state_q;
    logic [ID_W-1:0]      last_grant_q;
    logic                 first_run_q;
    logic [N_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;
    logic [BIT_WIDTH-1:0] op_sel;
    logic                 fin_seen;
    logic                 wdt_abort;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) op_sel = req_data[i*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? pick_grant : '0;
    assign sq_start  = (state_q == ST_START);
    assign res_valid = (state_q == ST_OUT);
    // The engine may still show finish from its previous idle period on the first RUN cycle.
    assign fin_seen  = (state_q == ST_RUN) && sq_finish && !first_run_q;

`ifdef SQRT_ARB_WDT_EN
    localparam int WDT_LIM = wdt_limit(BIT_WIDTH);
    localparam int WDT_W   = $clog2(WDT_LIM);

    logic [WDT_W-1:0] wdt_cnt_q;
    logic             res_err_q;

    assign wdt_abort = (state_q == ST_RUN) && !fin_seen && (wdt_cnt_q == '0);
    assign res_err   = res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            if (state_q == ST_START) begin
                wdt_cnt_q <= WDT_W'(WDT_LIM - 1);
            end else if ((state_q == ST_RUN) && (wdt_cnt_q != '0)) begin
                wdt_cnt_q <= wdt_cnt_q - 1'b1;
            end
            if (fin_seen) begin
                res_err_q <= 1'b0;
            end else if (wdt_abort) begin
                res_err_q <= 1'b1;
            end
        end
    end
`else
    assign wdt_abort = 1'b0;
    assign res_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            last_grant_q <= ID_W'(N_REQ - 1);
            first_run_q  <= 1'b0;
            sq_x         <= '0;
            res_data     <= '0;
            res_id       <= '0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (sq_finish) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        sq_x         <= op_sel;
                        res_id       <= pick_idx;
                        last_grant_q <= pick_idx;
                        state_q      <= ST_START;
                    end
                end
                ST_START: begin
                    first_run_q <= 1'b1;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    first_run_q <= 1'b0;
                    if (fin_seen) begin
                        res_data <= sq_result;
                        state_q  <= ST_OUT;
                    end else if (wdt_abort) begin
                        res_data <= '0;
                        state_q  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

endmodule
